rv_rr_arb: RTL and testbench

RV_RR_ARB -- requirements
Module: rv_rr_arb

---
 rtl/rv_pkg.sv | 21 ++
 rtl/rr_pick.sv | 34 +++
 rtl/rv_rr_arb.sv | 132 +++++++++++++
 tb/tb_rv_rr_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the round-robin valid/ready arbiter.
//   clog2()     : index-width helper (ceil(log2(v)), minimum 1)
//   lock_st_e   : packet-lock states, only used when RV_ARB_LOCK_EN is defined
//   LockRstSt   : lock state taken on reset
package rv_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } lock_st_e;

  localparam lock_st_e LockRstSt = StIdle;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     [n]  : request vector
//   ptr     [iw] : highest-priority index, search runs upward and wraps n-1 -> 0
//   gnt     [n]  : one-hot grant (all zero when no request)
//   gnt_idx [iw] : index of the granted request (0 when none)
//   any_req      : at least one request is present
module rr_pick #(
  parameter int unsigned n  = 4,
  parameter int unsigned iw = 2
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [iw-1:0] gnt_idx,
  output logic          any_req
);

  always_comb begin
    int w_idx;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < int'(n); k++) begin
      w_idx = (int'(ptr) + k) % int'(n);
      if (!any_req && req[w_idx]) begin
        any_req    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx[iw-1:0];
      end
    end
  end

endmodule

// File: rtl/rv_rr_arb.sv
// rv_rr_arb: n-input round-robin arbiter with valid/ready handshakes and a
// single registered output slot (one-cycle latency, full throughput).
//   clk, rst     : clock, synchronous active-high reset
//   datain_val   : per-requester valid
//   datain_rdy   : per-requester ready, at most one bit high
//   datain       : packed payloads, requester i at [i*wd +: wd]
//   datain_last  : per-requester last-beat flag (lock build only)
//   dataout_val  : registered output valid
//   dataout_rdy  : downstream ready
//   dataout      : registered payload
//   dataout_id   : index of the requester that supplied dataout
// Optional feature: define RV_ARB_LOCK_EN to keep the grant on one requester
// until it presents a beat with datain_last set.
module rv_rr_arb
  import rv_pkg::*;
#(
  parameter int unsigned wd = 4,
  parameter int unsigned n  = 4,
  parameter int unsigned iw = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [n-1:0]    datain_val,
  output logic [n-1:0]    datain_rdy,
  input  logic [n*wd-1:0] datain,
  input  logic [n-1:0]    datain_last,
  output logic            dataout_val,
  input  logic            dataout_rdy,
  output logic [wd-1:0]   dataout,
  output logic [iw-1:0]   dataout_id
);

  logic          r_val;
  logic [wd-1:0] r_data;
  logic [iw-1:0] r_id;
  logic [iw-1:0] r_ptr;

  logic [n-1:0]  w_req;
  logic [n-1:0]  w_gnt;
  logic [iw-1:0] w_idx;
  logic          w_any;
  logic          w_free;
  logic          w_xfer;
  logic [wd-1:0] w_sel;
  logic [iw-1:0] w_idx_nxt;

`ifdef RV_ARB_LOCK_EN
  lock_st_e      r_lock;
  logic [iw-1:0] r_owner;

  // While locked, only the owner may compete.
  always_comb begin
    w_req = datain_val;
    if (r_lock == StLocked) begin
      w_req          = '0;
      w_req[r_owner] = datain_val[r_owner];
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^datain_last;
  assign w_req         = datain_val;
`endif

  rr_pick #(
    .n  (n),
    .iw (iw)
  ) u_pick (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .any_req (w_any)
  );

  assign w_free     = !r_val || dataout_rdy;
  assign datain_rdy = (w_free && !rst) ? w_gnt : '0;
  assign w_xfer     = w_free && w_any && !rst;

  always_comb begin
    w_sel     = datain[int'(w_idx)*wd +: wd];
    w_idx_nxt = (int'(w_idx) == int'(n) - 1) ? '0 : w_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
`ifdef RV_ARB_LOCK_EN
      r_lock  <= LockRstSt;
      r_owner <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_val  <= 1'b1;
        r_data <= w_sel;
        r_id   <= w_idx;
`ifdef RV_ARB_LOCK_EN
        unique case (r_lock)
          StIdle: begin
            r_ptr <= w_idx_nxt;
            if (!datain_last[w_idx]) begin
              r_lock  <= StLocked;
              r_owner <= w_idx;
            end
          end
          StLocked: begin
            // Pointer stays frozen across the packet; the final beat
            // releases the lock and moves past the owner.
            if (datain_last[w_idx]) begin
              r_lock <= StIdle;
              r_ptr  <= w_idx_nxt;
            end
          end
          default: r_lock <= StIdle;
        endcase
`else
        r_ptr <= w_idx_nxt;
`endif
      end else if (dataout_rdy) begin
        r_val <= 1'b0;
      end
    end
  end

  assign dataout_val = r_val;
  assign dataout     = r_data;
  assign dataout_id  = r_id;

endmodule

// File: tb/tb_rv_rr_arb.sv
// tb_rv_rr_arb: directed scoreboard bench for rv_rr_arb (n=4, wd=4).
// The stimulus process pushes hand-computed {id, data} beats into a queue; a
// monitor pops and compares on every output transfer.
module tb_rv_rr_arb;

  localparam int unsigned WD = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    datain_val;
  logic [N-1:0]    datain_rdy;
  logic [N*WD-1:0] datain;
  logic [N-1:0]    datain_last;
  logic            dataout_val;
  logic            dataout_rdy;
  logic [WD-1:0]   dataout;
  logic [IW-1:0]   dataout_id;

  int n_pass  = 0;
  int n_total = 0;

  logic [IW+WD-1:0] exp_q[$];

  rv_rr_arb #(
    .wd (WD),
    .n  (N),
    .iw (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .datain_val  (datain_val),
    .datain_rdy  (datain_rdy),
    .datain      (datain),
    .datain_last (datain_last),
    .dataout_val (dataout_val),
    .dataout_rdy (dataout_rdy),
    .dataout     (dataout),
    .dataout_id  (dataout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input int v);
    datain[i*WD +: WD] = WD'(v);
  endtask

  task automatic push(input int data, input int id);
    exp_q.push_back({IW'(id), WD'(data)});
  endtask

  // Output monitor: a transfer happens at the next posedge when val&&rdy here.
  always @(negedge clk) begin
    logic [IW+WD-1:0] e;
    if (dataout_val && dataout_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", int'(dataout), int'(e[WD-1:0]));
        check("beat_id", int'(dataout_id), int'(e[IW+WD-1:WD]));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    datain_val  = '1;
    datain      = '0;
    datain_last = '1;
    dataout_rdy = 1'b0;

    // Reset with every requester valid.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_rdy", int'(datain_rdy), 0);
      check("rst_val", int'(dataout_val), 0);
      check("rst_id", int'(dataout_id), 0);
      step();
    end

    // Rotation: all valid, datain[i]=i+1.
    for (int i = 0; i < 4; i++) set_data(i, i + 1);
    push(1, 0); push(2, 1); push(3, 2); push(4, 3); push(1, 0);
    rst         = 1'b0;
    datain_val  = 4'b1111;
    dataout_rdy = 1'b1;
    for (int c = 0; c < 5; c++) step();
    datain_val = '0;
    step();
    check("rot_drain_q", exp_q.size(), 0);
    check("rot_drain_val", int'(dataout_val), 0);

    // Backpressure: ptr=1, requester 1 sends 5, then 6 waits behind it.
    set_data(1, 5);
    datain_val = 4'b0010;
    step();
    check("bp_load_data", int'(dataout), 5);
    set_data(1, 6);
    dataout_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_data", int'(dataout), 5);
      check("bp_hold_val", int'(dataout_val), 1);
      check("bp_hold_rdy", int'(datain_rdy), 0);
      step();
    end
    push(5, 1); push(6, 1);
    dataout_rdy = 1'b1;
    step();
    datain_val = '0;
    check("bp_next_data", int'(dataout), 6);
    check("bp_next_val", int'(dataout_val), 1);
    step();
    check("bp_drop_val", int'(dataout_val), 0);
    check("bp_hold_after", int'(dataout), 6);

    // Single requester 2, payloads 1..8 back to back.
    datain_val = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      set_data(2, k);
      push(k, 2);
      step();
    end
    datain_val = '0;
    step();
    check("single_drain_q", exp_q.size(), 0);
    check("single_drain_val", int'(dataout_val), 0);

    // Mid-reset with a held beat (grant 3 since ptr=3).
    datain_val  = 4'b1111;
    dataout_rdy = 1'b0;
    step();
    check("mr_held_val", int'(dataout_val), 1);
    check("mr_held_id", int'(dataout_id), 3);
    datain_val = '0;
    rst        = 1'b1;
    @(negedge clk);
    check("mr_rst_rdy", int'(datain_rdy), 0);
    step();
    check("mr_val_cleared", int'(dataout_val), 0);
    rst         = 1'b0;
    datain_val  = 4'b1111;
    dataout_rdy = 1'b1;
    push(1, 0);
    step();
    datain_val = '0;
    check("mr_first_id", int'(dataout_id), 0);
    step();
    step();
    check("mr_drain_q", exp_q.size(), 0);

`ifdef RV_ARB_LOCK_EN
    // Lock: ptr=1; requester 1 sends 3-beat packet while requester 0 waits.
    set_data(0, 9);
    datain_last = 4'b0001;
    datain_val  = 4'b0011;
    push(1, 1); push(2, 1); push(3, 1); push(9, 0);
    set_data(1, 1);
    step();
    set_data(1, 2);
    step();
    set_data(1, 3);
    datain_last = 4'b0011;
    step();
    datain_val = 4'b0001;
    step();
    datain_val = '0;
    step();
    step();
    check("lock_drain_q", exp_q.size(), 0);
`endif

    check("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the script is fixed-length, so this only fires on a stall.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
